// File: rtl/entrada_senha.sv
// Input-side controller for the safe: debounces the confirm button, latches the switch attempt,
// reads back the comparator verdict, counts consecutive failures and enforces a timed lockout.
module entrada_senha #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_ERROS       = 3,
    parameter int LOCK_CYCLES     = 250000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] chaves,
    input  logic       confirma_n,
    input  logic       igual,
    output logic [3:0] tentativa,
    output logic       tentativa_valida,
    output logic       aberto,
    output logic       bloqueado,
    output logic [1:0] erros
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCK_CYCLES - 1);
    localparam logic [LK_W-1:0] LK_ONE  = LK_W'(1);
    localparam logic [1:0]      ERR_MAX = 2'(MAX_ERROS);
    localparam logic [2:0]      ERR_LIM = 3'(MAX_ERROS);

    typedef enum logic [1:0] {OCIOSO, AVALIA, ABERTO, BLOQUEADO} estado_t;

    logic [1:0]      sync_q;
    logic            db_level_q, db_level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;

    estado_t         estado_q;
    logic [LK_W-1:0] lock_q;
    logic [3:0]      tent_q;
    logic            valid_q;
    logic            aberto_q;
    logic            bloq_q;
    logic [1:0]      erros_q;
    logic [2:0]      erros_inc;

    // Level must disagree with the debounced value for DEBOUNCE_CYCLES samples in a row to flip it
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        press_d    = 1'b0;
        if (sync_q[1] == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_level_d = sync_q[1];
            db_cnt_d   = '0;
            press_d    = ~sync_q[1];
        end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], confirma_n};
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

    assign erros_inc = {1'b0, erros_q} + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            lock_q   <= '0;
            tent_q   <= '0;
            valid_q  <= 1'b0;
            aberto_q <= 1'b0;
            bloq_q   <= 1'b0;
            erros_q  <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (press_q) begin
                        tent_q   <= chaves;
                        valid_q  <= 1'b1;
                        estado_q <= AVALIA;
                    end
                end
                AVALIA: begin
                    valid_q <= 1'b0;
                    if (igual) begin
                        estado_q <= ABERTO;
                        aberto_q <= 1'b1;
                        erros_q  <= '0;
                    end else if (erros_inc == ERR_LIM) begin
                        estado_q <= BLOQUEADO;
                        bloq_q   <= 1'b1;
                        erros_q  <= ERR_MAX;
                        lock_q   <= LK_LOAD;
                    end else begin
                        estado_q <= OCIOSO;
                        erros_q  <= erros_inc[1:0];
                    end
                end
                ABERTO: begin
                    if (press_q) begin
                        estado_q <= OCIOSO;
                        aberto_q <= 1'b0;
                    end
                end
                BLOQUEADO: begin
                    // Presses are deliberately not looked at while locked, even on the expiry cycle
                    if (lock_q == '0) begin
                        estado_q <= OCIOSO;
                        bloq_q   <= 1'b0;
                        erros_q  <= '0;
                    end else begin
                        lock_q <= lock_q - LK_ONE;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign tentativa        = tent_q;
    assign tentativa_valida = valid_q;
    assign aberto           = aberto_q;
    assign bloqueado        = bloq_q;
    assign erros            = erros_q;

endmodule

// File: doc/entrada_senha.md
Name: entrada_senha

Overview:
- Input-side controller for the safe; the other end of the comparator interface.
- Debounces the confirm button and latches the user's 4-bit attempt from the switches.
- Presents the latched attempt to the comparator, then reads back its equality verdict.
- Tracks consecutive wrong attempts and locks the safe for a fixed time after MAX_ERROS failures.

Parameters:
DEBOUNCE_CYCLES  50000  consecutive stable samples required to accept a button level change (1 ms @ 50 MHz)
MAX_ERROS  3  consecutive wrong attempts that trigger lockout (1..3)
LOCK_CYCLES  250000000  lockout duration in clock cycles (5 s @ 50 MHz)

Ports:
clk  input  1  system clock; the only clock
rst_n  input  1  asynchronous active-low reset
chaves  input  4  raw switch value holding the user's attempt
confirma_n  input  1  raw confirm push-button, active-low, asynchronous to clk
igual  input  1  comparator verdict: 1 when the latched attempt equals the stored password
tentativa  output  4  latched attempt, wired to the comparator
tentativa_valida  output  1  high for exactly one cycle while the comparator result is being sampled
aberto  output  1  safe open
bloqueado  output  1  lockout active
erros  output  2  current count of consecutive wrong attempts

Behaviour:
- Reset (rst_n=0, asynchronous): state OCIOSO; tentativa=0, tentativa_valida=0, aberto=0, bloqueado=0, erros=0; debounce and lock counters cleared; debounced button level = released (1).
- Reset asserted mid-operation aborts everything, including lockout. No state survives reset.
- Synchroniser: confirma_n passes through 2 flops before any use. chaves is sampled only at latch time and is not synchronised; switches are assumed static while the button is pressed.
- Debounce:
  - Counter resets whenever the synchronised level equals the current debounced level.
  - Otherwise the counter increments.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - `press` is a 1-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- FSM states: OCIOSO, AVALIA, ABERTO, BLOQUEADO.
  - OCIOSO: on press, tentativa<=chaves and go to AVALIA.
  - AVALIA (exactly 1 cycle):
    - tentativa_valida=1; igual is sampled at the end of this cycle.
    - If igual=1: go to ABERTO, erros<=0.
    - Else if erros+1 == MAX_ERROS: go to BLOQUEADO, erros<=MAX_ERROS, lock counter<=LOCK_CYCLES-1.
    - Else: go to OCIOSO, erros<=erros+1.
  - ABERTO: aberto=1. On press, go to OCIOSO (safe closed); tentativa is unchanged.
  - BLOQUEADO: bloqueado=1 and presses are ignored. The lock counter decrements each cycle. When it reads 0, go to OCIOSO and set erros<=0.
- Latency:
  - press pulse at cycle N.
  - tentativa updated and tentativa_valida=1 in cycle N+1.
  - aberto, bloqueado or erros updated in cycle N+2.
- All outputs are registered. aberto and bloqueado are decoded from registered state, so no combinational path exists from any input to any output.
- erros never exceeds MAX_ERROS. It is cleared only by a correct attempt, lockout expiry, or reset.
- A press arriving in AVALIA cannot occur, since debounce spacing exceeds 1 cycle. If one is forced, it is ignored.
- A press on the same cycle the lock counter reaches 0 is ignored; the FSM still returns to OCIOSO.
- Lock and debounce counter widths are $clog2 of their parameter. Counters never wrap.

Test Plan:
Bench params for all scenarios: DEBOUNCE_CYCLES=4, LOCK_CYCLES=20, MAX_ERROS=3.
- Reset/idle:
  - Stimulus: rst_n low then high; hold confirma_n=1 for 50 cycles.
  - Required: all outputs 0, tentativa_valida never asserts.
- Debounce:
  - Stimulus: toggle confirma_n 1->0->1 with each level held 2 cycles, repeated 10 times.
  - Required: no tentativa_valida pulse.
  - Stimulus: hold 0 for 6 cycles.
  - Required: exactly one tentativa_valida pulse.
- Correct attempt:
  - Stimulus: model comparator with password 4'h9; chaves=4'h9, valid press.
  - Required: tentativa=9 with tentativa_valida=1 for 1 cycle; aberto=1 on the next cycle; erros=0.
  - Stimulus: second press.
  - Required: aberto=0.
- Wrong then right:
  - Stimulus: chaves=4'h2, press; then chaves=4'h9, press.
  - Required: erros=1 after the first press; after the second press, aberto=1 and erros=0.
- Lockout:
  - Stimulus: three wrong presses (4'h0, 4'h1, 4'h2).
  - Required: erros=3, bloqueado=1 for exactly 20 cycles.
  - Stimulus: correct press during lockout.
  - Required: ignored, aberto stays 0.
  - Required after expiry: bloqueado=0, erros=0; next correct press opens.
- Reset mid-lockout:
  - Stimulus: pull rst_n low 5 cycles into lockout, asynchronously (not clock-aligned).
  - Required: bloqueado and erros drop to 0 immediately; a correct press after release opens the safe.
